// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared encodings for the two-port memory arbiter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - combinational two-requester round-robin pick
module rr_arbiter_2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = PORT_I;
    case (req_i)
      2'b01:   grant_idx_o = PORT_I;
      2'b10:   grant_idx_o = PORT_D;
      // contested: the port that did not win last time goes first
      2'b11:   grant_idx_o = ~last_grant_i;
      default: grant_idx_o = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of I-side and D-side cache ports onto one RAM
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  input  logic              p0_MemRead,
  input  logic              p0_MemWrite,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_ready,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  input  logic              p1_MemRead,
  input  logic              p1_MemWrite,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_MemRead,
  output logic              mem_MemWrite,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              req_idx_q, req_idx_d;
  op_e               req_op_q, req_op_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] req_data_q, req_data_d;
  logic [DATA_W-1:0] resp_q, resp_d;
  logic [DATA_W-1:0] p0_hold_q, p0_hold_d;
  logic [DATA_W-1:0] p1_hold_q, p1_hold_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;

  logic grant_valid;
  logic grant_idx;
  op_e  sel_op;

  rr_arbiter_2 u_rr (
    .req_i         ({p1_MemRead | p1_MemWrite, p0_MemRead | p0_MemWrite}),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT_D;
      req_idx_q    <= PORT_I;
      req_op_q     <= OP_RD;
      req_addr_q   <= '0;
      req_data_q   <= '0;
      resp_q       <= '0;
      p0_hold_q    <= '0;
      p1_hold_q    <= '0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      req_idx_q    <= req_idx_d;
      req_op_q     <= req_op_d;
      req_addr_q   <= req_addr_d;
      req_data_q   <= req_data_d;
      resp_q       <= resp_d;
      p0_hold_q    <= p0_hold_d;
      p1_hold_q    <= p1_hold_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    req_idx_d    = req_idx_q;
    req_op_d     = req_op_q;
    req_addr_d   = req_addr_q;
    req_data_d   = req_data_q;
    resp_d       = resp_q;
    p0_hold_d    = p0_hold_q;
    p1_hold_d    = p1_hold_q;
    rd_d         = 1'b0;
    wr_d         = 1'b0;
    sel_op       = OP_RD;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          // a port raising both strobes is treated as a write
          if (grant_idx == PORT_I) begin
            sel_op     = p0_MemWrite ? OP_WR : OP_RD;
            req_addr_d = p0_addr;
            req_data_d = p0_data;
          end else begin
            sel_op     = p1_MemWrite ? OP_WR : OP_RD;
            req_addr_d = p1_addr;
            req_data_d = p1_data;
          end
          req_idx_d    = grant_idx;
          req_op_d     = sel_op;
          last_grant_d = grant_idx;
          rd_d         = (sel_op == OP_RD);
          wr_d         = (sel_op == OP_WR);
          state_d      = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          resp_d  = mem_rdata;
          state_d = ST_DONE;
        end else begin
          rd_d = (req_op_q == OP_RD);
          wr_d = (req_op_q == OP_WR);
        end
      end
      ST_DONE: begin
        if (req_idx_q == PORT_I) p0_hold_d = resp_q;
        else                     p1_hold_d = resp_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr     = req_addr_q;
  assign mem_data     = req_data_q;
  assign mem_MemRead  = rd_q;
  assign mem_MemWrite = wr_q;

  assign p0_ready = (state_q == ST_DONE) && (req_idx_q == PORT_I);
  assign p1_ready = (state_q == ST_DONE) && (req_idx_q == PORT_D);
  assign p0_rdata = p0_ready ? resp_q : p0_hold_q;
  assign p1_rdata = p1_ready ? resp_q : p1_hold_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

  logic        iCLK;
  logic        iRST;
  logic [31:0] p0_addr, p0_data, p0_rdata;
  logic        p0_MemRead, p0_MemWrite, p0_ready;
  logic [31:0] p1_addr, p1_data, p1_rdata;
  logic        p1_MemRead, p1_MemWrite, p1_ready;
  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic        mem_MemRead, mem_MemWrite, mem_ready;

  int n_tests;
  int n_fail;

  logic [31:0] exp_rdata [2];
  logic        exp_known [2];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .p0_addr      (p0_addr),
    .p0_data      (p0_data),
    .p0_MemRead   (p0_MemRead),
    .p0_MemWrite  (p0_MemWrite),
    .p0_rdata     (p0_rdata),
    .p0_ready     (p0_ready),
    .p1_addr      (p1_addr),
    .p1_data      (p1_data),
    .p1_MemRead   (p1_MemRead),
    .p1_MemWrite  (p1_MemWrite),
    .p1_rdata     (p1_rdata),
    .p1_ready     (p1_ready),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_MemRead  (mem_MemRead),
    .mem_MemWrite (mem_MemWrite),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    @(negedge iCLK);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " mem_addr"},  mem_addr, 32'h0);
    check({tag, " mem_data"},  mem_data, 32'h0);
    check({tag, " mem_rd"},    32'(mem_MemRead), 32'h0);
    check({tag, " mem_wr"},    32'(mem_MemWrite), 32'h0);
    check({tag, " p0_ready"},  32'(p0_ready), 32'h0);
    check({tag, " p1_ready"},  32'(p1_ready), 32'h0);
    check({tag, " p0_rdata"},  p0_rdata, 32'h0);
    check({tag, " p1_rdata"},  p1_rdata, 32'h0);
  endtask

  // IDLE -> BUSY edge, then check the forwarded request
  task automatic start_txn(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [31:0] data);
    tick();
    check({tag, " addr"},   mem_addr, addr);
    check({tag, " data"},   mem_data, data);
    check({tag, " rd"},     32'(mem_MemRead), 32'(!wr));
    check({tag, " wr"},     32'(mem_MemWrite), 32'(wr));
    check({tag, " rdy0 busy"}, 32'(p0_ready), 32'h0);
    check({tag, " rdy1 busy"}, 32'(p1_ready), 32'h0);
  endtask

  // remaining BUSY cycles, RAM answer, and the DONE-cycle response
  task automatic end_txn(input string tag, input logic port, input logic [31:0] addr,
                         input logic wr, input int busy, input logic [31:0] rdata);
    logic other;
    other = ~port;
    for (int i = 0; i < busy; i++) begin
      tick();
      check({tag, " hold addr"}, mem_addr, addr);
      check({tag, " hold rd"},   32'(mem_MemRead), 32'(!wr));
      check({tag, " hold wr"},   32'(mem_MemWrite), 32'(wr));
    end
    mem_ready = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ready = 1'b0;
    mem_rdata = 32'hFFFF_FFFF;
    check({tag, " own ready"},   32'(port ? p1_ready : p0_ready), 32'h1);
    check({tag, " other ready"}, 32'(port ? p0_ready : p1_ready), 32'h0);
    check({tag, " rd drop"},     32'(mem_MemRead), 32'h0);
    check({tag, " wr drop"},     32'(mem_MemWrite), 32'h0);
    if (!wr) check({tag, " rdata"}, port ? p1_rdata : p0_rdata, rdata);
    if (exp_known[other]) check({tag, " other rdata"}, port ? p0_rdata : p1_rdata, exp_rdata[other]);
    exp_rdata[port] = rdata;
    exp_known[port] = !wr;
  endtask

  task automatic idle_chk(input string tag);
    tick();
    check({tag, " rdy0 idle"}, 32'(p0_ready), 32'h0);
    check({tag, " rdy1 idle"}, 32'(p1_ready), 32'h0);
    check({tag, " strobes idle"}, 32'({mem_MemRead, mem_MemWrite}), 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    iRST = 1'b1;
    p0_addr = '0; p0_data = '0; p0_MemRead = 1'b0; p0_MemWrite = 1'b0;
    p1_addr = '0; p1_data = '0; p1_MemRead = 1'b0; p1_MemWrite = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_known[0] = 1'b1; exp_known[1] = 1'b1;

    tick();
    tick();
    check_all_zero("reset");
    iRST = 1'b0;
    tick();

    // single read on port 0, RAM answers on its second strobe cycle
    p0_addr = 32'h40; p0_MemRead = 1'b1;
    start_txn("rd0", 32'h40, 1'b0, 32'h0);
    end_txn("rd0", 1'b0, 32'h40, 1'b0, 1, 32'hDEAD_BEEF);
    p0_MemRead = 1'b0;
    idle_chk("rd0");
    check("rd0 rdata hold", p0_rdata, 32'hDEAD_BEEF);

    // contention from a fresh reset: strict alternation starting with p0
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_known[0] = 1'b1; exp_known[1] = 1'b1;
    p0_addr = 32'h100; p0_MemRead = 1'b1;
    p1_addr = 32'h200; p1_MemRead = 1'b1;
    start_txn("ct1", 32'h100, 1'b0, 32'h0);
    end_txn("ct1", 1'b0, 32'h100, 1'b0, 0, 32'h1111_0001);
    idle_chk("ct1");
    start_txn("ct2", 32'h200, 1'b0, 32'h0);
    end_txn("ct2", 1'b1, 32'h200, 1'b0, 0, 32'h2222_0002);
    idle_chk("ct2");
    start_txn("ct3", 32'h100, 1'b0, 32'h0);
    end_txn("ct3", 1'b0, 32'h100, 1'b0, 1, 32'h1111_0003);
    idle_chk("ct3");
    start_txn("ct4", 32'h200, 1'b0, 32'h0);
    end_txn("ct4", 1'b1, 32'h200, 1'b0, 0, 32'h2222_0004);
    p0_MemRead = 1'b0; p1_MemRead = 1'b0;
    idle_chk("ct4");

    // write on port 1
    p1_addr = 32'h84; p1_data = 32'h1234_5678; p1_MemWrite = 1'b1;
    start_txn("wr1", 32'h84, 1'b1, 32'h1234_5678);
    end_txn("wr1", 1'b1, 32'h84, 1'b1, 2, 32'h0BAD_0BAD);
    p1_MemWrite = 1'b0; p1_data = '0;
    idle_chk("wr1");

    // late arrival: p1 shows up while p0 is in BUSY
    p0_addr = 32'h300; p0_MemRead = 1'b1;
    start_txn("late0", 32'h300, 1'b0, 32'h0);
    p1_addr = 32'h400; p1_MemRead = 1'b1;
    end_txn("late0", 1'b0, 32'h300, 1'b0, 1, 32'h3333_3333);
    p0_MemRead = 1'b0;
    idle_chk("late0");
    start_txn("late1", 32'h400, 1'b0, 32'h0);
    end_txn("late1", 1'b1, 32'h400, 1'b0, 0, 32'h4444_4444);
    p1_MemRead = 1'b0;
    idle_chk("late1");

    // both strobes on port 0 means write
    p0_addr = 32'h500; p0_data = 32'hA5A5_A5A5; p0_MemRead = 1'b1; p0_MemWrite = 1'b1;
    start_txn("both", 32'h500, 1'b1, 32'hA5A5_A5A5);
    end_txn("both", 1'b0, 32'h500, 1'b1, 1, 32'h0);
    p0_MemRead = 1'b0; p0_MemWrite = 1'b0; p0_data = '0;
    idle_chk("both");

    // last grant was p0, so the contested pick goes to p1; reset it mid-BUSY
    p0_addr = 32'h600; p0_MemRead = 1'b1;
    p1_addr = 32'h700; p1_MemRead = 1'b1;
    start_txn("rst", 32'h700, 1'b0, 32'h0);
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_7777;
    iRST = 1'b1;
    #1;
    check_all_zero("rst async");
    tick();
    check("rst rdy0", 32'(p0_ready), 32'h0);
    check("rst rdy1", 32'(p1_ready), 32'h0);
    iRST = 1'b0;
    mem_ready = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    exp_known[0] = 1'b1; exp_known[1] = 1'b1;
    start_txn("post", 32'h600, 1'b0, 32'h0);
    end_txn("post", 1'b0, 32'h600, 1'b0, 0, 32'h6666_6666);
    p0_MemRead = 1'b0; p1_MemRead = 1'b0;
    idle_chk("post");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter between the cache controllers and the single RAM/memory controller. Port 0 serves the instruction-side cache controller and port 1 the data-side cache controller. Both use the same MemRead/MemWrite/ready handshake the cache controller drives toward RAM. The arbiter grants one request at a time with round-robin fairness, registers the winning request, forwards it to RAM, and returns the RAM result only to the granted port.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- iCLK  in  1  clock; all state updates on rising edge
- iRST  in  1  reset, asynchronous, active-high
- p0_addr  in  ADDR_W  port 0 request address
- p0_data  in  DATA_W  port 0 write data
- p0_MemRead  in  1  port 0 read request (level)
- p0_MemWrite  in  1  port 0 write request (level)
- p0_rdata  out  DATA_W  read data returned to port 0
- p0_ready  out  1  port 0 completion pulse
- p1_addr, p1_data, p1_MemRead, p1_MemWrite, p1_rdata, p1_ready: same as port 0, for port 1
- mem_addr  out  ADDR_W  RAM address
- mem_data  out  DATA_W  RAM write data
- mem_MemRead  out  1  RAM read strobe (level)
- mem_MemWrite  out  1  RAM write strobe (level)
- mem_rdata  in  DATA_W  RAM read data
- mem_ready  in  1  RAM completion

## Operation
- A port requests when its MemRead or MemWrite is high. The requester holds addr, data and strobe stable until its ready pulse, then deasserts or presents a new request in the following cycle.
- If a port raises both MemRead and MemWrite, the request is a write.
- FSM states:
  - IDLE: if no port requests, stay. Otherwise pick a winner: the only requester, or, when both request, the port that was not last granted. At the edge, latch winner index, addr, data and op into req registers, update last_grant, and go to BUSY.
  - BUSY: mem_addr and mem_data come from the req registers. mem_MemRead or mem_MemWrite follows the latched op. On mem_ready: capture mem_rdata into the resp register (writes also capture, value is don't-care), drop both RAM strobes at the edge, and go to DONE.
  - DONE: the granted port's ready is high for exactly this cycle, and its rdata equals the resp register. The next state is always IDLE.
- Port inputs are ignored outside IDLE. A request arriving mid-transaction waits, with no loss.
- mem_ready is ignored in IDLE and DONE.
- Port rdata holds its last captured value until overwritten. The non-granted port's rdata is unchanged.
- last_grant resets to port 1, so port 0 wins the first contested arbitration.

## Timing
- Reset:
  - All outputs are 0.
  - State is IDLE, last_grant is 1, and the req/resp registers are 0.
  - Asserting reset mid-transaction aborts immediately: RAM strobes drop asynchronously and no ready is issued.
- Request latency: a request seen in IDLE at edge N puts the RAM strobe high from cycle N+1.
- Response latency: mem_ready high in cycle M gives the port ready in cycle M+1, for one cycle.
- Minimum transaction with a RAM that answers in its first strobe cycle is 3 cycles: IDLE, BUSY, DONE.
- Back-to-back requests from the same port get 1 idle cycle between transactions.
- RAM strobes are registered outputs, glitch-free and never both high.
- Contested traffic alternates grants strictly: p0, p1, p0, …

## Structure
- Package mem_arbiter_pkg: state encoding (IDLE, BUSY, DONE), port index constants (PORT_I = 0, PORT_D = 1), op encoding (OP_RD, OP_WR).
- Sub-module rr_arbiter_2: combinational two-requester round-robin pick. Inputs are req[1:0] and last_grant; outputs are grant_valid and grant_idx. Everything else stays in mem_arbiter.

## Test plan
- Single read: p0_MemRead, p0_addr = 0x40, RAM returns 0xDEADBEEF after 2 strobe cycles. Expect mem_addr = 0x40, p0_ready for 1 cycle with p0_rdata = 0xDEADBEEF, p1_ready stays 0.
- Contention: both ports read continuously from reset (p0 at 0x100, p1 at 0x200). Expect mem_addr sequence 0x100, 0x200, 0x100, 0x200, with each ready going only to its own port.
- Write: p1_MemWrite, addr 0x84, data 0x12345678. Expect mem_MemWrite = 1 with mem_data = 0x12345678 until mem_ready, then p1_ready pulses and mem_MemRead never rises.
- Late arrival: p1 requests while p0's transaction is in BUSY. Expect no change to mem_addr and p1 served immediately after p0's DONE.
- Both strobes on one port: p0_MemRead = p0_MemWrite = 1. Expect only mem_MemWrite asserted.
- Reset mid-BUSY: assert iRST while mem_MemRead = 1. Expect all outputs 0 immediately, no ready pulse, and after release the next contested arbitration goes to p0.
